// File: rtl/crack_result_collector.sv
// Collects the first successful RC4 search core, stops all cores, and streams the
// winner's decrypted message out of its A RAM over a valid/ready byte interface.
module crack_result_collector #(
  parameter int unsigned NUM_CORES          = 55,
  parameter int unsigned CORE_IDX_W         = 6,
  parameter int unsigned KEY_BITS           = 24,
  parameter int unsigned MESSAGE_LENGTH     = 32,
  parameter int unsigned MESSAGE_LOG_LENGTH = 5,
  parameter int unsigned RAM_WIDTH          = 8,
  parameter int unsigned RD_LATENCY         = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          arm,
  input  logic [NUM_CORES-1:0]          core_success,
  input  logic [NUM_CORES-1:0]          core_done,
  input  logic [NUM_CORES*KEY_BITS-1:0] core_key,
  output logic                          kill,
  output logic [CORE_IDX_W-1:0]         rd_core,
  output logic [MESSAGE_LOG_LENGTH-1:0] rd_addr,
  input  logic [RAM_WIDTH-1:0]          rd_data,
  output logic [RAM_WIDTH-1:0]          out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          found,
  output logic                          failed,
  output logic [CORE_IDX_W-1:0]         win_core,
  output logic [KEY_BITS-1:0]           win_key
);

  typedef enum logic [2:0] {
    StIdle, StSearch, StKill, StIssue, StWait, StSend, StDone, StFail
  } state_e;

  localparam logic [MESSAGE_LOG_LENGTH-1:0] LastAddr = MESSAGE_LOG_LENGTH'(MESSAGE_LENGTH - 1);

  state_e                        state_q, state_d;
  logic [1:0]                    cnt_q, cnt_d;
  logic                          kill_q, kill_d;
  logic [CORE_IDX_W-1:0]         rd_core_q, rd_core_d;
  logic [MESSAGE_LOG_LENGTH-1:0] rd_addr_q, rd_addr_d;
  logic [RAM_WIDTH-1:0]          out_data_q, out_data_d;
  logic                          out_valid_q, out_valid_d;
  logic                          out_last_q, out_last_d;
  logic                          found_q, found_d;
  logic                          failed_q, failed_d;
  logic [CORE_IDX_W-1:0]         win_core_q, win_core_d;
  logic [KEY_BITS-1:0]           win_key_q, win_key_d;

  logic                          any_hit;
  logic [CORE_IDX_W-1:0]         hit_idx;
  logic [KEY_BITS-1:0]           hit_key;

  // Descending scan so the lowest set index is the last one written.
  always_comb begin
    any_hit = |core_success;
    hit_idx = '0;
    hit_key = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (core_success[i]) begin
        hit_idx = CORE_IDX_W'(i);
        hit_key = core_key[i*KEY_BITS +: KEY_BITS];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    kill_d      = 1'b0;
    rd_core_d   = rd_core_q;
    rd_addr_d   = rd_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    found_d     = found_q;
    failed_d    = failed_q;
    win_core_d  = win_core_q;
    win_key_d   = win_key_q;

    unique case (state_q)
      StIdle: ;
      StSearch: begin
        // Success takes priority over an all-done in the same cycle.
        if (any_hit) begin
          win_core_d = hit_idx;
          win_key_d  = hit_key;
          rd_core_d  = hit_idx;
          rd_addr_d  = '0;
          kill_d     = 1'b1;
          found_d    = 1'b1;
          state_d    = StKill;
        end else if (&core_done) begin
          failed_d = 1'b1;
          state_d  = StFail;
        end
      end
      StKill:  state_d = StIssue;
      StIssue: begin
        cnt_d   = 2'(RD_LATENCY);
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q <= 2'd1) begin
          out_data_d  = rd_data;
          out_valid_d = 1'b1;
          out_last_d  = (rd_addr_q == LastAddr);
          state_d     = StSend;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StSend: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            state_d = StDone;
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
            state_d   = StIssue;
          end
        end
      end
      StDone, StFail: ;
      default: state_d = StIdle;
    endcase

    // arm restarts collection from any state, dropping whatever was in flight.
    if (arm) begin
      state_d     = StSearch;
      cnt_d       = '0;
      kill_d      = 1'b0;
      rd_core_d   = '0;
      rd_addr_d   = '0;
      out_data_d  = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      found_d     = 1'b0;
      failed_d    = 1'b0;
      win_core_d  = '0;
      win_key_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      kill_q      <= 1'b0;
      rd_core_q   <= '0;
      rd_addr_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      found_q     <= 1'b0;
      failed_q    <= 1'b0;
      win_core_q  <= '0;
      win_key_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      kill_q      <= kill_d;
      rd_core_q   <= rd_core_d;
      rd_addr_q   <= rd_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      found_q     <= found_d;
      failed_q    <= failed_d;
      win_core_q  <= win_core_d;
      win_key_q   <= win_key_d;
    end
  end

  assign kill      = kill_q;
  assign rd_core   = rd_core_q;
  assign rd_addr   = rd_addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign found     = found_q;
  assign failed    = failed_q;
  assign win_core  = win_core_q;
  assign win_key   = win_key_q;

endmodule

// File: tb/tb_crack_result_collector.sv
// Scoreboard bench for crack_result_collector: expected message bytes are queued when a
// winner is stimulated and popped as the DUT hands bytes over.
module tb_crack_result_collector;

  localparam int unsigned NumCores   = 55;
  localparam int unsigned IdxW       = 6;
  localparam int unsigned KeyBits    = 24;
  localparam int unsigned MsgLen     = 32;
  localparam int unsigned MsgLogLen  = 5;
  localparam int unsigned RamW       = 8;
  localparam int unsigned RdLatency  = 1;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        arm;
  logic [NumCores-1:0]         core_success;
  logic [NumCores-1:0]         core_done;
  logic [NumCores*KeyBits-1:0] core_key;
  logic                        kill;
  logic [IdxW-1:0]             rd_core;
  logic [MsgLogLen-1:0]        rd_addr;
  logic [RamW-1:0]             rd_data;
  logic [RamW-1:0]             out_data;
  logic                        out_valid;
  logic                        out_ready;
  logic                        out_last;
  logic                        found;
  logic                        failed;
  logic [IdxW-1:0]             win_core;
  logic [KeyBits-1:0]          win_key;

  crack_result_collector #(
    .NUM_CORES         (NumCores),
    .CORE_IDX_W        (IdxW),
    .KEY_BITS          (KeyBits),
    .MESSAGE_LENGTH    (MsgLen),
    .MESSAGE_LOG_LENGTH(MsgLogLen),
    .RAM_WIDTH         (RamW),
    .RD_LATENCY        (RdLatency)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .arm         (arm),
    .core_success(core_success),
    .core_done   (core_done),
    .core_key    (core_key),
    .kill        (kill),
    .rd_core     (rd_core),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .found       (found),
    .failed      (failed),
    .win_core    (win_core),
    .win_key     (win_key)
  );

  always #5 clk = ~clk;

  // A RAM model: byte at address a reads as a + 8'h41, RdLatency cycles after rd_addr.
  logic [RamW-1:0] lat_pipe [RdLatency];
  always @(posedge clk) begin
    lat_pipe[0] <= 8'(rd_addr) + 8'h41;
    for (int i = 1; i < RdLatency; i++) lat_pipe[i] <= lat_pipe[i-1];
  end
  assign rd_data = lat_pipe[RdLatency-1];

  int n_checks = 0;
  int n_pass   = 0;
  int byte_cnt = 0;
  int kill_cnt = 0;
  int valid_cnt = 0;
  logic [8:0] sb [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Handshake completes on the posedge following a negedge that sees valid & ready.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (kill) kill_cnt++;
      if (out_valid) valid_cnt++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", {out_last, out_data}, 64'h1ff);
        end else begin
          check("byte", {out_last, out_data}, sb.pop_front());
        end
        byte_cnt++;
      end
    end
  end

  task automatic push_msg();
    for (int i = 0; i < MsgLen; i++) sb.push_back({(i == MsgLen - 1), 8'(i) + 8'h41});
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(posedge clk);
    #1 arm = 1'b0;
  endtask

  task automatic wait_bytes(input int target, input int budget);
    int n = 0;
    while (byte_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("byte_count", byte_cnt, target);
  endtask

  int base;
  int k0;
  int v0;

  initial begin
    reset = 1'b0; arm = 1'b0; out_ready = 1'b1;
    core_success = '0; core_done = '0; core_key = '0;
    #3;
    check("rst_flags", {kill, out_valid, out_last, found, failed}, 0);
    check("rst_idx", {rd_core, rd_addr, win_core}, 0);
    check("rst_data", {out_data, win_key}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    // Single winner, full stream at full rate; a late success must be ignored.
    pulse_arm();
    base = byte_cnt; k0 = kill_cnt;
    core_key[7*KeyBits +: KeyBits] = 24'h0A1B2C;
    core_success[7] = 1'b1;
    push_msg();
    @(posedge clk); #1;
    check("kill_pulse", kill, 1);
    check("win_core7", win_core, 7);
    check("win_key7", win_key, 24'h0A1B2C);
    check("found_a", found, 1);
    check("rd_core7", rd_core, 7);
    core_success[2] = 1'b1;
    @(posedge clk); #1;
    check("kill_one_cycle", kill, 0);
    wait_bytes(base + MsgLen, 400);
    repeat (3) @(posedge clk); #1;
    check("sb_empty_a", sb.size(), 0);
    check("done_quiet", {out_valid, found, win_core}, {1'b0, 1'b1, 6'd7});
    check("done_addr", rd_addr, MsgLen - 1);
    check("kill_count_a", kill_cnt, k0 + 1);
    core_success = '0;

    // Simultaneous successes, stream with a 5-cycle consumer stall.
    pulse_arm();
    base = byte_cnt;
    core_key[3*KeyBits +: KeyBits]  = 24'h333333;
    core_key[40*KeyBits +: KeyBits] = 24'h404040;
    core_success[3] = 1'b1; core_success[40] = 1'b1;
    push_msg();
    @(posedge clk); #1;
    check("win_core3", win_core, 3);
    check("win_key3", win_key, 24'h333333);
    core_success = '0;
    wait_bytes(base + 12, 200);
    #1 out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (k >= 2) check("stall_hold", {out_valid, out_data}, {1'b1, 8'h4D});
    end
    out_ready = 1'b1;
    wait_bytes(base + MsgLen, 400);
    repeat (2) @(posedge clk); #1;
    check("sb_empty_b", sb.size(), 0);
    check("valid_low_b", out_valid, 0);

    // All cores exhausted without success.
    pulse_arm();
    k0 = kill_cnt; v0 = valid_cnt;
    core_done = '1;
    @(posedge clk); #1;
    check("fail_flags", {failed, found}, 2'b10);
    repeat (10) @(posedge clk); #1;
    check("fail_no_kill", kill_cnt, k0);
    check("fail_no_valid", valid_cnt, v0);
    check("fail_sticky", failed, 1);
    core_done = '0;

    // Abort mid-stream with arm, then restart on a new winner.
    pulse_arm();
    check("arm_clears_failed", failed, 0);
    base = byte_cnt;
    core_success[7] = 1'b1;
    push_msg();
    wait_bytes(base + 10, 200);
    #1 arm = 1'b1;
    core_success = '0;
    @(posedge clk); #1 arm = 1'b0;
    sb.delete();
    check("abort_state", {out_valid, found, win_core, win_key}, 0);
    base = byte_cnt;
    core_key[0 +: KeyBits] = 24'h123456;
    core_success[0] = 1'b1;
    push_msg();
    @(posedge clk); #1;
    check("restart_win", {win_core, win_key}, {6'd0, 24'h123456});
    check("restart_addr", rd_addr, 0);
    core_success = '0;
    wait_bytes(base + 5, 100);

    // Asynchronous reset mid-stream.
    #3 reset = 1'b0;
    #1;
    check("async_rst_flags", {kill, out_valid, out_last, found, failed}, 0);
    check("async_rst_rest", {rd_core, rd_addr, out_data, win_core, win_key}, 0);
    sb.delete();
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
